// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op and FSM state encodings for the iterative
//                add/subtract/compare engine.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef logic [1:0] alu_op_t;
    typedef logic [1:0] alu_state_t;

    localparam alu_op_t ALU_OP_ADD  = 2'b00;
    localparam alu_op_t ALU_OP_SUB  = 2'b01;
    localparam alu_op_t ALU_OP_SLT  = 2'b10;
    localparam alu_op_t ALU_OP_SLTU = 2'b11;

    localparam alu_state_t ST_IDLE = 2'd0;
    localparam alu_state_t ST_RUN  = 2'd1;
    localparam alu_state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_chunk_add.sv
`default_nettype none
// ============================================================================
//  Module      : alu_chunk_add
//  Description : CHUNK-bit combinational adder slice with carry in/out.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};

endmodule
`default_nettype wire

// File: rtl/alu_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_addsub_seq
//  Description : Multi-cycle add/sub/slt/sltu engine, CHUNK bits per cycle
//                through a registered carry chain, start/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] c_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int c_N     = WIDTH / CHUNK;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    alu_state_t         r_state;
    alu_state_t         w_next;
    logic               w_ready;
    logic               w_done;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    alu_op_t            r_op;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;

    logic [WIDTH-1:0]   r_c;
    logic               r_zero;
    logic               r_neg;
    logic               r_cy;
    logic               r_ovf;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_s_chunk;
    logic               w_co;
    logic [WIDTH-1:0]   w_s_full;
    logic               w_v;
    logic [WIDTH-1:0]   w_res;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_next = ST_RUN;
            ST_RUN:  if (r_idx == c_LAST) w_next = ST_DONE;
            ST_DONE: w_next = start_i ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
        w_done  = (r_state == ST_DONE);
    end

    assign w_accept = start_i && w_ready;
    assign w_last   = (r_state == ST_RUN) && (r_idx == c_LAST);

    // ---------------- chunk datapath ----------------
    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

    alu_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a_i  (w_a_chunk),
        .b_i  (w_b_chunk),
        .ci_i (r_carry),
        .s_o  (w_s_chunk),
        .co_o (w_co)
    );

    // On the last chunk the top slice is still in flight, so splice it in.
    always_comb begin
        w_s_full                  = r_sum;
        w_s_full[WIDTH-1 -: CHUNK] = w_s_chunk;
    end

    assign w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s_full[WIDTH-1] != r_a[WIDTH-1]);

    always_comb begin
        w_res = w_s_full;
        case (r_op)
            ALU_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_s_full[WIDTH-1] ^ w_v};
            ALU_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, ~w_co};
            default:     w_res = w_s_full;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_op    <= ALU_OP_ADD;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_c     <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_cy    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_i;
            r_b     <= (op_i != ALU_OP_ADD) ? ~b_i : b_i;
            r_op    <= op_i;
            r_carry <= (op_i != ALU_OP_ADD);
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum[r_idx*CHUNK +: CHUNK] <= w_s_chunk;
            r_carry <= w_co;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_c    <= w_res;
                r_zero <= (w_res == '0);
                r_neg  <= w_s_full[WIDTH-1];
                r_cy   <= w_co;
                r_ovf  <= w_v;
            end
        end
    end

    assign ready_o = w_ready;
    assign done_o  = w_done;
    assign c_o     = r_c;
    assign zero_o  = r_zero;
    assign neg_o   = r_neg;
    assign carry_o = r_cy;
    assign ovf_o   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_addsub_seq
//  Description : Scoreboard bench for alu_addsub_seq at CHUNK=8, 32 and 1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_addsub_seq;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;      // {zero, neg, carry, ovf}
        int          acc;
        int          lat;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, sw;
    logic [1:0]  op8, opw;
    logic [31:0] a8, b8, aw, bw;

    logic        rdy8, dn8, z8, n8, cy8, v8;
    logic        rdy32, dn32, z32, n32, cy32, v32;
    logic        rdy1, dn1, z1, n1, cy1, v1;
    logic [31:0] c8, c32, c1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q8[$];
    exp_t q32[$];
    exp_t q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    alu_addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(s8), .op_i(op8), .a_i(a8), .b_i(b8),
        .ready_o(rdy8), .done_o(dn8), .c_o(c8),
        .zero_o(z8), .neg_o(n8), .carry_o(cy8), .ovf_o(v8));

    alu_addsub_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(sw), .op_i(opw), .a_i(aw), .b_i(bw),
        .ready_o(rdy32), .done_o(dn32), .c_o(c32),
        .zero_o(z32), .neg_o(n32), .carry_o(cy32), .ovf_o(v32));

    alu_addsub_seq #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(sw), .op_i(opw), .a_i(aw), .b_i(bw),
        .ready_o(rdy1), .done_o(dn1), .c_o(c1),
        .zero_o(z1), .neg_o(n1), .carry_o(cy1), .ovf_o(v1));

    task automatic cmp(input string name, input int id, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s #%0d: got 0x%08h, required 0x%08h", name, id, got, req);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic [31:0] c,
                              input logic [3:0] f, input logic rdy);
        cmp({tag, ".c"},     e.id, c, e.c);
        cmp({tag, ".flags"}, e.id, {28'b0, f}, {28'b0, e.f});
        cmp({tag, ".lat"},   e.id, cyc - e.acc, e.lat);
        cmp({tag, ".ready"}, e.id, {31'b0, rdy}, 32'd1);
    endtask

    task automatic unexpected(input string tag);
        n_cmp++;
        n_bad++;
        $display("FAIL %s unexpected done: got done_o=1, required 0", tag);
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (dn8) begin
            if (q8.size() == 0) unexpected("dut8");
            else begin e = q8.pop_front(); check_done("dut8", e, c8, {z8, n8, cy8, v8}, rdy8); end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dn32) begin
            if (q32.size() == 0) unexpected("dut32");
            else begin e = q32.pop_front(); check_done("dut32", e, c32, {z32, n32, cy32, v32}, rdy32); end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dn1) begin
            if (q1.size() == 0) unexpected("dut1");
            else begin e = q1.pop_front(); check_done("dut1", e, c1, {z1, n1, cy1, v1}, rdy1); end
        end
    end

    // Returns at the negedge just before the accepting edge; start stays high.
    task automatic issue8(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ec, input logic [3:0] ef, input bit push, input int id);
        int   k = 0;
        exp_t e;
        @(negedge clk);
        s8 = 1'b1; op8 = op; a8 = a; b8 = b;
        while (!rdy8 && k < 100) begin @(negedge clk); k++; end
        if (!rdy8) begin
            n_cmp++; n_bad++;
            $display("FAIL issue8 #%0d timeout: got ready_o=0, required 1", id);
        end
        e.c = ec; e.f = ef; e.acc = cyc + 1; e.lat = 4; e.id = id;
        if (push) q8.push_back(e);
    endtask

    task automatic issue_w(input logic op, input logic [31:0] a, input logic [31:0] b, input int id);
        int          k = 0;
        exp_t        e;
        logic [32:0] t;
        @(negedge clk);
        sw = 1'b1; opw = {1'b0, op}; aw = a; bw = b;
        while (!(rdy32 && rdy1) && k < 100) begin @(negedge clk); k++; end
        if (!(rdy32 && rdy1)) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_w #%0d timeout: got ready=0, required 1", id);
        end
        if (!op) begin
            t   = {1'b0, a} + {1'b0, b};
            e.c = t[31:0];
            e.f = {e.c == 32'd0, e.c[31], t[32], (a[31] == b[31]) && (e.c[31] != a[31])};
        end else begin
            e.c = a - b;
            e.f = {e.c == 32'd0, e.c[31], a >= b, (a[31] != b[31]) && (e.c[31] != a[31])};
        end
        e.acc = cyc + 1; e.id = id;
        e.lat = 1;  q32.push_back(e);
        e.lat = 32; q1.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        @(negedge clk);
        s8 = 1'b0; sw = 1'b0;
        while ((q8.size() != 0 || q32.size() != 0 || q1.size() != 0) && k < 300) begin
            @(negedge clk); k++;
        end
        n_cmp++;
        if (q8.size() != 0 || q32.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain timeout: got %0d pending, required 0", q8.size() + q32.size() + q1.size());
        end
    endtask

    initial begin
        rst = 1'b1; s8 = 1'b0; sw = 1'b0;
        op8 = '0; opw = '0; a8 = '0; b8 = '0; aw = '0; bw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp("reset.ready", 0, {31'b0, rdy8}, 32'd1);
        cmp("reset.done",  0, {31'b0, dn8},  32'd0);
        cmp("reset.c",     0, c8, 32'd0);
        cmp("reset.flags", 0, {28'b0, z8, n8, cy8, v8}, 32'd0);
        cmp("reset.ready_w", 0, {30'b0, rdy32, rdy1}, 32'd3);

        // Directed vectors, flags {zero, neg, carry, ovf}
        issue8(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 1, 1); drain();
        issue8(2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0100, 1, 2); drain();
        issue8(2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 1, 3); drain();
        issue8(2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0110, 1, 4); drain();
        issue8(2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1110, 1, 5); drain();
        issue8(2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 4'b1101, 1, 6); drain();
        issue8(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 1, 7); drain();
        issue8(2'b01, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b1010, 1, 8); drain();
        issue8(2'b11, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 4'b0100, 1, 9); drain();

        // start pulsed mid-RUN with different operands must be ignored
        issue8(2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000, 1, 10);
        @(negedge clk); s8 = 1'b0;
        @(negedge clk); s8 = 1'b1; op8 = 2'b01; a8 = 32'hFFFF_FFFF; b8 = 32'hFFFF_FFFF;
        drain();

        // start held through DONE: back-to-back acceptance
        issue8(2'b01, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 4'b0010, 1, 11);
        issue8(2'b10, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0011, 1, 12);
        drain();

        // reset while chunk 2 is being processed
        issue8(2'b01, 32'h0000_0005, 32'h0000_0007, 32'h0, 4'b0000, 0, 13);
        @(negedge clk); s8 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        cmp("midrst.ready", 13, {31'b0, rdy8}, 32'd1);
        cmp("midrst.done",  13, {31'b0, dn8},  32'd0);
        cmp("midrst.c",     13, c8, 32'd0);
        cmp("midrst.flags", 13, {28'b0, z8, n8, cy8, v8}, 32'd0);
        repeat (6) @(negedge clk);

        issue8(2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000, 1, 14); drain();

        // CHUNK=32 and CHUNK=1 instances against the reference model
        issue_w(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 100); drain();
        issue_w(1'b1, 32'h8000_0000, 32'h0000_0001, 101); drain();
        for (int i = 0; i < 8; i++) begin
            issue_w(1'($urandom_range(0, 1)), $urandom, $urandom, 102 + i);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
